net_msg_sender: RTL and testbench

NET_MSG_SENDER -- requirements
Module: net_msg_sender

---
 rtl/net_msg_sender_pkg.sv | 31 +++
 rtl/net_msg_sender_fifo2.sv | 101 ++++++++++
 rtl/net_msg_sender.sv | 72 +++++++
 tb/tb_net_msg_sender.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/net_msg_sender_pkg.sv
// Shared network-message definitions: header layout, header width and
// the occupancy encoding used by the sender's two-entry queue.
package net_msg_sender_pkg;

    localparam int unsigned c_net_hdr_nbits = 12;

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] src;
        logic [7:0] opaque;
    } net_hdr_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_occ_t;

    function automatic net_hdr_t mk_hdr(
        input logic [1:0] dest,
        input logic [1:0] src,
        input logic [7:0] opaque
    );
        net_hdr_t h;
        h.dest   = dest;
        h.src    = src;
        h.opaque = opaque;
        return h;
    endfunction

endpackage

// File: rtl/net_msg_sender_fifo2.sv
// Two-entry in-order queue whose head entry is a register, so the
// dequeue side never sees a combinational path from the enqueue side.
module net_sender_fifo2
    import net_msg_sender_pkg::*;
#(
    parameter int unsigned p_nbits = 44
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_nbits-1:0] enq_msg,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_nbits-1:0] deq_msg
);

    fifo_occ_t state_q;
    fifo_occ_t state_d;

    logic [p_nbits-1:0] head_q;
    logic [p_nbits-1:0] tail_q;

    logic enq_fire;
    logic deq_fire;
    logic head_we;
    logic head_from_tail;
    logic tail_we;

    assign enq_rdy  = (state_q != FIFO_FULL);
    assign deq_val  = (state_q != FIFO_EMPTY);
    assign deq_msg  = head_q;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FIFO_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_we        = 1'b0;
        head_from_tail = 1'b0;
        tail_we        = 1'b0;
        unique case (state_q)
            FIFO_EMPTY: begin
                if (enq_fire) begin
                    state_d = FIFO_ONE;
                    head_we = 1'b1;
                end
            end
            FIFO_ONE: begin
                // Simultaneous enq+deq replaces the head in place.
                unique case ({enq_fire, deq_fire})
                    2'b10: begin
                        state_d = FIFO_FULL;
                        tail_we = 1'b1;
                    end
                    2'b01: begin
                        state_d = FIFO_EMPTY;
                    end
                    2'b11: begin
                        head_we = 1'b1;
                    end
                    default: begin
                        state_d = FIFO_ONE;
                    end
                endcase
            end
            FIFO_FULL: begin
                if (deq_fire) begin
                    state_d        = FIFO_ONE;
                    head_we        = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_d = FIFO_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (head_we) begin
                head_q <= head_from_tail ? tail_q : enq_msg;
            end
            if (tail_we) begin
                tail_q <= enq_msg;
            end
        end
    end

endmodule

// File: rtl/net_msg_sender.sv
// Network terminal sender: stamps client requests with a header and a
// rolling tag, queues them, and counts messages taken by the network.
module net_msg_sender
    import net_msg_sender_pkg::*;
#(
    parameter int unsigned p_payload_nbits = 32,
    parameter int unsigned p_node_id       = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_val,
    output logic                                    req_rdy,
    input  logic [1:0]                              req_dest,
    input  logic [p_payload_nbits-1:0]              req_payload,
    output logic                                    out_val,
    input  logic                                    out_rdy,
    output logic [c_net_hdr_nbits+p_payload_nbits-1:0] out_msg,
    output logic [15:0]                             num_sent
);

    localparam int unsigned c_msg_nbits = c_net_hdr_nbits + p_payload_nbits;
    localparam logic [1:0]  c_src       = 2'(p_node_id);

    logic [7:0]             tag_q;
    logic [15:0]            sent_q;
    logic                   fifo_enq_rdy;
    logic                   fifo_deq_val;
    logic                   req_go;
    logic                   out_go;
    net_hdr_t               hdr;
    logic [c_msg_nbits-1:0] enq_msg;

    // Handshakes are masked during reset so nothing moves or is counted.
    assign req_rdy  = fifo_enq_rdy && !reset;
    assign out_val  = fifo_deq_val && !reset;
    assign req_go   = req_val && req_rdy;
    assign out_go   = out_val && out_rdy;
    assign num_sent = reset ? 16'h0000 : sent_q;

    assign hdr     = mk_hdr(req_dest, c_src, tag_q);
    assign enq_msg = {hdr, req_payload};

    net_sender_fifo2 #(
        .p_nbits (c_msg_nbits)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_val (req_val && !reset),
        .enq_rdy (fifo_enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (fifo_deq_val),
        .deq_rdy (out_rdy && !reset),
        .deq_msg (out_msg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= 8'h00;
        end else if (req_go) begin
            tag_q <= tag_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sent_q <= 16'h0000;
        end else if (out_go && (sent_q != 16'hFFFF)) begin
            sent_q <= sent_q + 16'h0001;
        end
    end

endmodule

// File: tb/tb_net_msg_sender.sv
// Directed vector table plus scoreboard runs for net_msg_sender
// configured as node 2 with a 32-bit payload.
module tb_net_msg_sender;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [1:0]  req_dest;
    logic [31:0] req_payload;
    logic        out_val;
    logic        out_rdy;
    logic [43:0] out_msg;
    logic [15:0] num_sent;

    int checks   = 0;
    int failures = 0;

    net_msg_sender #(
        .p_payload_nbits (32),
        .p_node_id       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_dest    (req_dest),
        .req_payload (req_payload),
        .out_val     (out_val),
        .out_rdy     (out_rdy),
        .out_msg     (out_msg),
        .num_sent    (num_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [1:0]  d;
        logic [31:0] pay;
        logic        ordy;
        logic        e_rdy;
        logic        e_val;
        logic [43:0] e_msg;
        logic [15:0] e_ns;
    } vec_t;

    vec_t tv[27];

    function automatic logic [43:0] mk(
        input logic [1:0]  d,
        input logic [7:0]  t,
        input logic [31:0] p
    );
        return {d, 2'd2, t, p};
    endfunction

    function automatic vec_t v(
        input logic        rst,
        input logic        rv,
        input logic [1:0]  d,
        input logic [31:0] pay,
        input logic        ordy,
        input logic        e_rdy,
        input logic        e_val,
        input logic [43:0] e_msg,
        input logic [15:0] e_ns
    );
        vec_t r;
        r.rst   = rst;
        r.rv    = rv;
        r.d     = d;
        r.pay   = pay;
        r.ordy  = ordy;
        r.e_rdy = e_rdy;
        r.e_val = e_val;
        r.e_msg = e_msg;
        r.e_ns  = e_ns;
        return r;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard run: reference queue model of occupancy, tags and order.
    task automatic run_sb(input int ncyc, input int nreq, input bit rnd);
        logic [43:0] q[$];
        logic [7:0]  tag;
        int          sent;
        int          acc;
        bit          deq;
        tag  = 8'h00;
        sent = 0;
        acc  = 0;
        reset   = 1'b1;
        req_val = 1'b0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            req_val     = rnd ? 1'($urandom_range(0, 1)) : (acc < nreq);
            req_dest    = 2'($urandom_range(0, 3));
            req_payload = $urandom;
            out_rdy     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            chk("sb_req_rdy", 64'(req_rdy), 64'(q.size() < 2));
            chk("sb_out_val", 64'(out_val), 64'(q.size() > 0));
            deq = 1'b0;
            if (q.size() > 0 && out_rdy) begin
                chk($sformatf("sb_msg[%0d]", sent), 64'(out_msg), 64'(q[0]));
                if (!rnd && sent == 255) begin
                    chk("wrap_msg256_opaque", 64'(out_msg[39:32]), 64'hFF);
                end
                if (!rnd && sent == 256) begin
                    chk("wrap_msg257_opaque", 64'(out_msg[39:32]), 64'h00);
                end
                deq = 1'b1;
            end
            if (deq) begin
                void'(q.pop_front());
                sent++;
            end
            if (req_val && (q.size() + (deq ? 1 : 0)) < 2) begin
                q.push_back(mk(req_dest, tag, req_payload));
                tag = tag + 8'h01;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        @(negedge clk);
        chk("sb_num_sent", 64'(num_sent), 64'(sent));
        if (!rnd) begin
            chk("wrap_num_sent", 64'(num_sent), 64'd257);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = v(1, 1, 2'd1, 32'hCAFE0001, 1, 0, 0, '0, 16'd0);
        tv[1]  = v(0, 1, 2'd1, 32'hCAFE0001, 1, 1, 0, '0, 16'd0);
        tv[2]  = v(0, 0, 2'd0, 32'h0, 1, 1, 1, mk(2'd1, 8'h00, 32'hCAFE0001), 16'd0);
        tv[3]  = v(0, 0, 2'd0, 32'h0, 1, 1, 0, '0, 16'd1);
        tv[4]  = v(1, 0, 2'd0, 32'h0, 1, 0, 0, '0, 16'd0);
        tv[5]  = v(0, 1, 2'd3, 32'hA0000000, 1, 1, 0, '0, 16'd0);
        tv[6]  = v(0, 1, 2'd0, 32'hA0000001, 1, 1, 1, mk(2'd3, 8'h00, 32'hA0000000), 16'd0);
        tv[7]  = v(0, 1, 2'd1, 32'hA0000002, 1, 1, 1, mk(2'd0, 8'h01, 32'hA0000001), 16'd1);
        tv[8]  = v(0, 1, 2'd2, 32'hA0000003, 1, 1, 1, mk(2'd1, 8'h02, 32'hA0000002), 16'd2);
        tv[9]  = v(0, 0, 2'd0, 32'h0, 1, 1, 1, mk(2'd2, 8'h03, 32'hA0000003), 16'd3);
        tv[10] = v(0, 0, 2'd0, 32'h0, 1, 1, 0, '0, 16'd4);
        tv[11] = v(1, 0, 2'd0, 32'h0, 0, 0, 0, '0, 16'd0);
        tv[12] = v(0, 1, 2'd1, 32'hB0000000, 0, 1, 0, '0, 16'd0);
        tv[13] = v(0, 1, 2'd1, 32'hB0000001, 0, 1, 1, mk(2'd1, 8'h00, 32'hB0000000), 16'd0);
        tv[14] = v(0, 1, 2'd1, 32'hB0000002, 0, 0, 1, mk(2'd1, 8'h00, 32'hB0000000), 16'd0);
        tv[15] = v(0, 1, 2'd1, 32'hB0000002, 0, 0, 1, mk(2'd1, 8'h00, 32'hB0000000), 16'd0);
        tv[16] = v(0, 1, 2'd1, 32'hB0000002, 1, 0, 1, mk(2'd1, 8'h00, 32'hB0000000), 16'd0);
        tv[17] = v(0, 1, 2'd1, 32'hB0000002, 1, 1, 1, mk(2'd1, 8'h01, 32'hB0000001), 16'd1);
        tv[18] = v(0, 0, 2'd0, 32'h0, 1, 1, 1, mk(2'd1, 8'h02, 32'hB0000002), 16'd2);
        tv[19] = v(0, 0, 2'd0, 32'h0, 1, 1, 0, '0, 16'd3);
        tv[20] = v(1, 0, 2'd0, 32'h0, 0, 0, 0, '0, 16'd0);
        tv[21] = v(0, 1, 2'd3, 32'hC0000000, 0, 1, 0, '0, 16'd0);
        tv[22] = v(0, 1, 2'd3, 32'hC0000001, 0, 1, 1, mk(2'd3, 8'h00, 32'hC0000000), 16'd0);
        tv[23] = v(1, 1, 2'd3, 32'hC0000002, 1, 0, 0, '0, 16'd0);
        tv[24] = v(0, 1, 2'd0, 32'hC0000003, 1, 1, 0, '0, 16'd0);
        tv[25] = v(0, 0, 2'd0, 32'h0, 1, 1, 1, mk(2'd0, 8'h00, 32'hC0000003), 16'd0);
        tv[26] = v(0, 0, 2'd0, 32'h0, 1, 1, 0, '0, 16'd1);

        reset       = 1'b1;
        req_val     = 1'b0;
        req_dest    = 2'd0;
        req_payload = 32'h0;
        out_rdy     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 27; i++) begin
            reset       = tv[i].rst;
            req_val     = tv[i].rv;
            req_dest    = tv[i].d;
            req_payload = tv[i].pay;
            out_rdy     = tv[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_req_rdy", i), 64'(req_rdy), 64'(tv[i].e_rdy));
            chk($sformatf("v%0d_out_val", i), 64'(out_val), 64'(tv[i].e_val));
            chk($sformatf("v%0d_num_sent", i), 64'(num_sent), 64'(tv[i].e_ns));
            if (tv[i].e_val) begin
                chk($sformatf("v%0d_out_msg", i), 64'(out_msg), 64'(tv[i].e_msg));
            end
            @(posedge clk);
            #1;
        end

        run_sb(260, 257, 1'b0);
        run_sb(1000, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
